// File: rtl/rf_dump_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : rf_dump_reader_pkg                                               |
// | Purpose : Shared register-file geometry and the dump-reader state codes.   |
// |           RF_AW / RF_DW are also used by the rf and the pipeline.          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package rf_dump_reader_pkg;

  localparam int RF_AW = 5;   // register index width
  localparam int RF_DW = 32;  // register data width

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;  // waiting for start
  localparam state_t ST_REQ  = 2'd1;  // holding dbg_req, waiting for grant
  localparam state_t ST_SEND = 2'd2;  // beat latched, waiting for sink
  localparam state_t ST_DONE = 2'd3;  // one-cycle completion pulse

endpackage : rf_dump_reader_pkg
`default_nettype wire

// File: rtl/rf_dump_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rf_dump_reader                                                   |
// | Purpose : Borrows an rf read port and streams x0..x(NUM_REGS-1) out on a   |
// |           valid/ready interface (index, data, last), one register/beat.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   clock, all state on posedge                              |
// |   rst_n      in   synchronous active-low reset                             |
// |   start      in   pulse: begin a scan (only honoured in IDLE)              |
// |   abort      in   cancel scan in progress                                  |
// |   busy       out  high whenever not IDLE                                   |
// |   done       out  one-cycle pulse after last beat accepted                 |
// |   dbg_req    out  request for the rf read port                             |
// |   dbg_gnt    in   read port granted this cycle                             |
// |   dbg_rR     out  rf read address                                          |
// |   dbg_rD     in   rf read data (combinational from dbg_rR)                 |
// |   out_valid  out  stream beat valid                                        |
// |   out_ready  in   sink accepts beat                                        |
// |   out_idx    out  register index of beat                                   |
// |   out_data   out  register value of beat                                   |
// |   out_last   out  beat carries index NUM_REGS-1                            |
// +----------------------------------------------------------------------------+
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int AW       = RF_AW,
  parameter int DW       = RF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          dbg_req,
  input  logic          dbg_gnt,
  output logic [AW-1:0] dbg_rR,
  input  logic [DW-1:0] dbg_rD,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam logic [AW-1:0] C_LAST_IDX = AW'(NUM_REGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  // State and beat register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state and beat-latch logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      ST_IDLE: begin
        // abort alongside start keeps us idle
        if (start && !abort) begin
          state_d = ST_REQ;
          idx_d   = '0;
        end
      end
      ST_REQ: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (dbg_gnt) begin
          // rf data is only valid in the grant cycle, so capture it here
          out_data_d  = dbg_rD;
          out_idx_d   = idx_q;
          out_last_d  = (idx_q == C_LAST_IDX);
          out_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort) begin
          // pending beat is dropped even if the sink is ready this cycle
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_REQ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control outputs
  always_comb begin
    busy    = (state_q != ST_IDLE);
    // an abort landing in DONE suppresses the completion pulse
    done    = (state_q == ST_DONE) && !abort;
    dbg_req = (state_q == ST_REQ) || (state_q == ST_SEND);
    dbg_rR  = dbg_req ? idx_q : '0;
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule : rf_dump_reader
`default_nettype wire

// File: tb/tb_rf_dump_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_rf_dump_reader                                                |
// | Purpose : Self-checking bench for rf_dump_reader: directed scenarios plus  |
// |           randomized grant/ready/start/abort/reset against a scan model.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_rf_dump_reader;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          dbg_req;
  logic          dbg_gnt;
  logic [AW-1:0] dbg_rR;
  logic [DW-1:0] dbg_rD;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_idx;
  logic [DW-1:0] out_data;
  logic          out_last;

  logic [DW-1:0] rf [0:N-1];
  assign dbg_rD = rf[dbg_rR];

  rf_dump_reader #(.NUM_REGS(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .dbg_req   (dbg_req),
    .dbg_gnt   (dbg_gnt),
    .dbg_rR    (dbg_rR),
    .dbg_rD    (dbg_rD),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scan-level reference: is a scan running, is a beat on the stream,
  // which register is next, is the completion pulse due.
  bit m_active  = 1'b0;
  bit m_pending = 1'b0;
  bit m_done    = 1'b0;
  int m_idx     = 0;
  int m_scans   = 0;
  int seen_done = 0;
  int cyc       = 0;
  int t_start   = -1;
  int t_first   = -1;
  int t_done    = -1;

  // One clock: inputs already applied; check outputs, advance model, wait.
  task automatic tick;
    #1;
    check("busy",      busy,      m_active || m_done);
    check("done",      done,      m_done && !abort);
    check("dbg_req",   dbg_req,   m_active);
    check("dbg_rR",    dbg_rR,    m_active ? m_idx : 0);
    check("out_valid", out_valid, m_pending);
    if (m_pending) begin
      check("out_idx",  out_idx,  m_idx);
      check("out_data", out_data, rf[m_idx]);
      check("out_last", out_last, m_idx == N - 1);
    end
    if (out_valid && t_first < 0) t_first = cyc;
    if (done) begin
      seen_done++;
      t_done = cyc;
    end

    if (m_done && !abort) m_scans++;
    if (!rst_n || (abort && (m_active || m_done))) begin
      m_active  = 1'b0;
      m_pending = 1'b0;
      m_done    = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (m_pending) begin
        if (out_ready) begin
          m_pending = 1'b0;
          if (m_idx == N - 1) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end else begin
            m_idx++;
          end
        end
      end else if (dbg_gnt) begin
        m_pending = 1'b1;
      end
    end else if (start && !abort) begin
      m_active  = 1'b1;
      m_pending = 1'b0;
      m_idx     = 0;
      t_start   = cyc;
      t_first   = -1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic defaults;
    start     = 1'b0;
    abort     = 1'b0;
    dbg_gnt   = 1'b1;
    out_ready = 1'b1;
    rst_n     = 1'b1;
  endtask

  task automatic run_idle(input int max);
    int k;
    k = 0;
    while (busy && k < max) begin
      tick;
      k++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic kick;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    int hold;
    int k;
    bit fired;

    defaults;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) rf[i] = 32'h1000 + i;
    rf[0] = '0;
    @(negedge clk);
    tick;
    tick;
    rst_n = 1'b1;
    check("rst_out_idx",  out_idx,  0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);

    // Full scan, continuous grant and ready
    kick;
    run_idle(200);
    check("first_valid_lat", t_first - t_start, 2);
    check("done_lat",        t_done - t_start,  2 * N + 1);
    check("scans_full",      seen_done,         1);

    // Backpressure on beat 3
    kick;
    hold = 0;
    k = 0;
    while (busy && k < 300) begin
      if (out_valid && out_idx == 3 && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      tick;
      k++;
    end
    check("bp_hold_cycles", hold, 5);
    check("scans_bp", seen_done, 2);

    // Grant stall in REQ idx 10
    kick;
    hold = 0;
    k = 0;
    while (busy && k < 300) begin
      if (dbg_req && !out_valid && dbg_rR == 10 && hold < 4) begin
        dbg_gnt = 1'b0;
        hold++;
      end else begin
        dbg_gnt = 1'b1;
      end
      tick;
      k++;
    end
    check("gnt_stall_cycles", hold, 4);
    check("scans_gnt", seen_done, 3);

    // Abort on beat 12 while the sink is ready
    kick;
    fired = 1'b0;
    k = 0;
    while (!fired && k < 300) begin
      if (out_valid && out_idx == 12) begin
        abort     = 1'b1;
        out_ready = 1'b1;
        fired     = 1'b1;
      end
      tick;
      k++;
    end
    abort = 1'b0;
    check("abort_seen",  fired,     1'b1);
    check("abort_busy",  busy,      1'b0);
    check("abort_valid", out_valid, 1'b0);
    for (int i = 0; i < 5; i++) tick;
    check("scans_abort", seen_done, 3);

    // Start pulses mid-scan are ignored; start+abort in IDLE stays idle
    kick;
    for (int i = 0; i < 40; i++) begin
      start = (i == 10 || i == 30);
      tick;
    end
    start = 1'b0;
    run_idle(200);
    check("scans_restart", seen_done, 4);
    start = 1'b1;
    abort = 1'b1;
    tick;
    defaults;
    check("start_abort_idle", busy, 1'b0);
    tick;
    check("scans_start_abort", seen_done, 4);

    // Reset while beat 7 is on the stream
    kick;
    k = 0;
    while (!(out_valid && out_idx == 7) && k < 300) begin
      tick;
      k++;
    end
    check("reach_beat7", out_idx, 7);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("mrst_busy",      busy,      0);
    check("mrst_done",      done,      0);
    check("mrst_dbg_req",   dbg_req,   0);
    check("mrst_dbg_rR",    dbg_rR,    0);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_idx",   out_idx,   0);
    check("mrst_out_data",  out_data,  0);
    check("mrst_out_last",  out_last,  0);

    // Randomized traffic
    for (int i = 1; i < N; i++) rf[i] = $urandom;
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom % 20) == 0;
      abort     = ($urandom % 80) == 0;
      dbg_gnt   = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      rst_n     = ($urandom % 700) != 0;
      tick;
    end
    defaults;
    run_idle(300);
    tick;
    check("scan_count", seen_done, m_scans);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule : tb_rf_dump_reader
`default_nettype wire
